// File: rtl/lcd_refresh_driver.sv
// Refreshes a 2x16 HD44780 LCD. It runs the power-up init once and then
// rewrites all 32 character cells continuously from the DisplayAddr/Phrase source.
module lcd_refresh_driver #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned EN_CYCLES      = 25,
  parameter int unsigned CMD_CYCLES     = 2500,
  parameter int unsigned CLEAR_CYCLES   = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] Phrase,
  output logic [4:0] DisplayAddr,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       FrameDone
);

  localparam int unsigned MAX_A      = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
  localparam int unsigned MAX_B      = (CMD_CYCLES > EN_CYCLES) ? CMD_CYCLES : EN_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [7:0] CMD_CLEAR = 8'h01;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_LINE, ST_FETCH, ST_WRITE, ST_NEXT
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_PULSE, PH_HOLD
  } phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [4:0]     addr_d;
  logic           load;
  logic           load_rs;
  logic [7:0]     load_data;
  logic           hold_last;
  logic [7:0]     data_d;
  logic           rs_d;
  logic           en_d;
  logic           fd_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] line_cmd(input logic [4:0] a);
    return a[4] ? 8'hC0 : 8'h80;
  endfunction

  // Last HOLD cycle; the clear command needs the long settle time.
  always_comb begin
    hold_last = 1'b0;
    if (!LCD_RS && (LCD_DATA == CMD_CLEAR))
      hold_last = (cnt_q == CW'(CLEAR_CYCLES - 1));
    else
      hold_last = (cnt_q == CW'(CMD_CYCLES - 1));
  end

  // State register; bus outputs are loaded from their next values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_POWERUP;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      DisplayAddr <= '0;
      LCD_DATA    <= 8'h00;
      LCD_RS      <= 1'b0;
      LCD_RW      <= 1'b0;
      LCD_EN      <= 1'b0;
      LCD_ON      <= 1'b0;
      FrameDone   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      DisplayAddr <= addr_d;
      LCD_DATA    <= data_d;
      LCD_RS      <= rs_d;
      LCD_RW      <= 1'b0;
      LCD_EN      <= en_d;
      LCD_ON      <= 1'b1;
      FrameDone   <= fd_d;
    end
  end

  // Next-state logic: sequencing, wait counting and which byte to put on the bus.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = DisplayAddr;
    load      = 1'b0;
    load_rs   = 1'b0;
    load_data = 8'h00;
    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
          state_d   = ST_INIT;
          phase_d   = PH_SETUP;
          cnt_d     = '0;
          idx_d     = 2'd0;
          load      = 1'b1;
          load_data = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_INIT, ST_LINE, ST_WRITE: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_PULSE;
            cnt_d   = '0;
          end
          PH_PULSE: begin
            if (cnt_q == CW'(EN_CYCLES - 1)) begin
              phase_d = PH_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PH_HOLD: begin
            if (hold_last) begin
              cnt_d   = '0;
              phase_d = PH_SETUP;
              if (state_q == ST_INIT && idx_q != 2'd3) begin
                idx_d     = idx_q + 2'd1;
                load      = 1'b1;
                load_data = init_cmd(idx_q + 2'd1);
              end else if (state_q == ST_INIT) begin
                state_d   = ST_LINE;
                addr_d    = 5'd0;
                load      = 1'b1;
                load_data = line_cmd(5'd0);
              end else if (state_q == ST_LINE) begin
                state_d = ST_FETCH;
              end else begin
                state_d = ST_NEXT;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: phase_d = PH_SETUP;
        endcase
      end
      ST_FETCH: begin
        // Phrase follows DisplayAddr one clock late, so take it on the 2nd clock.
        if (cnt_q == CW'(1)) begin
          state_d   = ST_WRITE;
          phase_d   = PH_SETUP;
          cnt_d     = '0;
          load      = 1'b1;
          load_rs   = 1'b1;
          load_data = Phrase;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_NEXT: begin
        phase_d = PH_SETUP;
        cnt_d   = '0;
        if (DisplayAddr == 5'd15 || DisplayAddr == 5'd31) begin
          addr_d    = (DisplayAddr == 5'd15) ? 5'd16 : 5'd0;
          state_d   = ST_LINE;
          load      = 1'b1;
          load_data = (DisplayAddr == 5'd15) ? line_cmd(5'd16) : line_cmd(5'd0);
        end else begin
          addr_d  = DisplayAddr + 5'd1;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: bus byte held for the whole transaction; EN high only in PULSE.
  always_comb begin
    data_d = LCD_DATA;
    rs_d   = LCD_RS;
    en_d   = 1'b0;
    fd_d   = 1'b0;
    if (load) begin
      data_d = load_data;
      rs_d   = load_rs;
    end
    if ((state_d == ST_INIT || state_d == ST_LINE || state_d == ST_WRITE) && phase_d == PH_PULSE)
      en_d = 1'b1;
    if (state_d == ST_NEXT && DisplayAddr == 5'd31)
      fd_d = 1'b1;
  end

endmodule

// File: tb/tb_lcd_refresh_driver.sv
// Directed bench for lcd_refresh_driver with a registered Phrase ROM and LCD bus monitor.
module tb_lcd_refresh_driver;

  localparam int unsigned P_PWR   = 20;
  localparam int unsigned P_EN    = 2;
  localparam int unsigned P_CMD   = 5;
  localparam int unsigned P_CLEAR = 10;

  logic       clock;
  logic       resetn;
  logic [7:0] Phrase;
  logic [4:0] DisplayAddr;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, FrameDone;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rom [0:31];
  logic       started = 1'b0;

  // Monitor records
  logic       ev_rs   [0:127];
  logic [7:0] ev_data [0:127];
  int         ev_low  [0:127];
  int         ev_n       = 0;
  int         low_cnt    = 0;
  int         hi_cnt     = 0;
  logic       prev_en    = 1'b0;
  logic       cap_rs     = 1'b0;
  logic [7:0] cap_data   = 8'h00;
  int         width_bad  = 0;
  int         unstable   = 0;
  int         rw_bad     = 0;
  int         fd_total   = 0;

  // Expected event list
  logic       exp_rs   [0:127];
  logic [7:0] exp_data [0:127];
  int         exp_low  [0:127];
  int         exp_n     = 0;
  int         prev_kind = 0;

  lcd_refresh_driver #(
    .POWERUP_CYCLES(P_PWR),
    .EN_CYCLES     (P_EN),
    .CMD_CYCLES    (P_CMD),
    .CLEAR_CYCLES  (P_CLEAR)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .Phrase     (Phrase),
    .DisplayAddr(DisplayAddr),
    .LCD_DATA   (LCD_DATA),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_EN     (LCD_EN),
    .LCD_ON     (LCD_ON),
    .FrameDone  (FrameDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Character ROM with one clock of registered latency
  always @(posedge clock) Phrase <= rom[DisplayAddr];

  // Bus monitor: capture (RS, DATA) at each EN rise, low time before it, EN width, stability
  always @(negedge clock) begin
    if (started && LCD_RW !== 1'b0) rw_bad <= rw_bad + 1;
    if (LCD_ON !== 1'b1) begin
      prev_en <= 1'b0;
      low_cnt <= 0;
      hi_cnt  <= 0;
    end else begin
      if (FrameDone === 1'b1) fd_total <= fd_total + 1;
      if (LCD_EN === 1'b1 && !prev_en) begin
        if (ev_n < 128) begin
          ev_rs[ev_n]   <= LCD_RS;
          ev_data[ev_n] <= LCD_DATA;
          ev_low[ev_n]  <= low_cnt;
        end
        ev_n     <= ev_n + 1;
        cap_rs   <= LCD_RS;
        cap_data <= LCD_DATA;
        hi_cnt   <= 1;
      end else if (LCD_EN === 1'b1) begin
        hi_cnt <= hi_cnt + 1;
        if ({LCD_RS, LCD_DATA} !== {cap_rs, cap_data}) unstable <= unstable + 1;
      end else if (prev_en) begin
        if (hi_cnt != int'(P_EN)) width_bad <= width_bad + 1;
        if ({LCD_RS, LCD_DATA} !== {cap_rs, cap_data}) unstable <= unstable + 1;
        low_cnt <= 1;
      end else begin
        low_cnt <= low_cnt + 1;
      end
      prev_en <= (LCD_EN === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected low samples before an EN rise: HOLD of the previous transaction,
  // NEXT after a character, FETCH before a character, plus the SETUP clock.
  task automatic push_exp(input logic rs, input logic [7:0] d);
    int low;
    int hold;
    hold = (prev_kind == 2) ? int'(P_CLEAR) : int'(P_CMD);
    if (prev_kind == 0) low = int'(P_PWR);
    else low = hold + ((prev_kind == 3) ? 1 : 0) + (rs ? 2 : 0) + 1;
    exp_rs[exp_n]   = rs;
    exp_data[exp_n] = d;
    exp_low[exp_n]  = low;
    exp_n++;
    prev_kind = rs ? 3 : ((d == 8'h01) ? 2 : 1);
  endtask

  function automatic logic [7:0] char_at(input int frame, input int a);
    if (a == 5) return (frame == 0) ? 8'h33 : 8'h37;
    return 8'h40 + 8'(a);
  endfunction

  task automatic wait_ev(input int n, input string tag);
    int k;
    k = 0;
    while (ev_n < n && k < 4000) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(ev_n >= n), 32'd1);
  endtask

  initial begin
    int k;
    int base;
    resetn = 1'b0;
    for (int a = 0; a < 32; a++) rom[a] = char_at(0, a);

    prev_kind = 0;
    push_exp(1'b0, 8'h38);
    push_exp(1'b0, 8'h0C);
    push_exp(1'b0, 8'h01);
    push_exp(1'b0, 8'h06);
    for (int f = 0; f < 2; f++) begin
      push_exp(1'b0, 8'h80);
      for (int a = 0; a < 16; a++) push_exp(1'b1, char_at(f, a));
      push_exp(1'b0, 8'hC0);
      for (int a = 16; a < 32; a++) push_exp(1'b1, char_at(f, a));
    end

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_en",   32'(LCD_EN),      32'd0);
    chk("rst_on",   32'(LCD_ON),      32'd0);
    chk("rst_addr", 32'(DisplayAddr), 32'd0);
    chk("rst_data", 32'(LCD_DATA),    32'd0);
    chk("rst_rs",   32'(LCD_RS),      32'd0);
    chk("rst_rw",   32'(LCD_RW),      32'd0);
    chk("rst_fd",   32'(FrameDone),   32'd0);
    started = 1'b1;
    resetn  = 1'b1;
    @(negedge clock);
    chk("on_after_release", 32'(LCD_ON), 32'd1);

    // Change address 5 while its frame-1 write is on the bus
    wait_ev(11, "wait_char5");
    chk("char5_en_high", 32'(LCD_EN), 32'd1);
    rom[5] = 8'h37;

    // End of frame 1: single FrameDone pulse with address wrap
    wait_ev(38, "wait_char31");
    k = 0;
    while (FrameDone !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("fd_seen",    32'(FrameDone),   32'd1);
    chk("fd_addr31",  32'(DisplayAddr), 32'd31);
    @(negedge clock);
    chk("fd_one_clk", 32'(FrameDone),   32'd0);
    chk("addr_wrap",  32'(DisplayAddr), 32'd0);
    chk("fd_total",   32'(fd_total),    32'd1);

    // Two full frames of bus traffic
    wait_ev(72, "wait_frame2");
    for (int i = 0; i < 72; i++) begin
      chk($sformatf("ev%0d_rs", i),   32'(ev_rs[i]),   32'(exp_rs[i]));
      chk($sformatf("ev%0d_data", i), 32'(ev_data[i]), 32'(exp_data[i]));
      chk($sformatf("ev%0d_low", i),  32'(ev_low[i]),  32'(exp_low[i]));
    end

    // Reset pulse on the first EN-high clock of the next transaction
    k = 0;
    while (LCD_EN !== 1'b0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    k = 0;
    while (LCD_EN !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("pre_reset_en", 32'(LCD_EN), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_en",   32'(LCD_EN),      32'd0);
    chk("midrst_addr", 32'(DisplayAddr), 32'd0);
    chk("midrst_on",   32'(LCD_ON),      32'd0);
    base   = ev_n;
    resetn = 1'b1;
    chk("midrst_base", 32'(base), 32'd73);

    // Full power-up and init repeat
    wait_ev(base + 5, "wait_reinit");
    chk("ri0_low",  32'(ev_low[base]),      32'd20);
    chk("ri0_data", 32'(ev_data[base]),     32'h38);
    chk("ri1_data", 32'(ev_data[base + 1]), 32'h0C);
    chk("ri1_low",  32'(ev_low[base + 1]),  32'd6);
    chk("ri2_data", 32'(ev_data[base + 2]), 32'h01);
    chk("ri3_data", 32'(ev_data[base + 3]), 32'h06);
    chk("ri3_low",  32'(ev_low[base + 3]),  32'd11);
    chk("ri4_data", 32'(ev_data[base + 4]), 32'h80);
    chk("ri4_rs",   32'(ev_rs[base + 4]),   32'd0);
    repeat (4) @(negedge clock);

    // Whole-run bus properties
    chk("en_width", 32'(width_bad), 32'd0);
    chk("stable",   32'(unstable),  32'd0);
    chk("rw_zero",  32'(rw_bad),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_driver.md
Name: lcd_refresh_driver

Overview:
- Consumer side of the DisplayAddr/Phrase character interface.
- Drives DisplayAddr 0..31, samples the returned 8-bit ASCII Phrase, and writes each character to a 2x16 HD44780-compatible LCD over an 8-bit parallel write-only bus.
- Runs the power-up init sequence once, then refreshes the whole screen continuously, so changes in address, data or R/W fields show up without any handshake from upstream.

Parameters:
- POWERUP_CYCLES, 750000, idle clocks after reset before the first command (15 ms at 50 MHz).
- EN_CYCLES, 25, LCD_EN high width in clocks (500 ns).
- CMD_CYCLES, 2500, wait after EN falls for any command or character (50 us).
- CLEAR_CYCLES, 100000, wait after the clear command 0x01 (2 ms).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- Phrase  in  8  ASCII character for the current DisplayAddr; valid 1 clock after DisplayAddr changes (registered ROM path).
- DisplayAddr  out  5  character position; 0-15 = line 1, 16-31 = line 2.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  0 = command, 1 = character data.
- LCD_RW  out  1  tied 0 (write only).
- LCD_EN  out  1  LCD enable strobe.
- LCD_ON  out  1  LCD power/backlight; 1 once out of reset.
- FrameDone  out  1  one-clock pulse after character 31 of each refresh completes.

Behaviour:
- Reset (resetn=0 sampled at a clock edge): state=POWERUP, delay counter=0, DisplayAddr=0, LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=0, FrameDone=0.
  - Reset mid-transaction drops LCD_EN on that same edge and restarts the full init.
- Bus transaction (shared by commands and characters):
  - SETUP: 1 clock, LCD_RS/LCD_DATA driven, LCD_EN=0.
  - PULSE: EN_CYCLES clocks with LCD_EN=1.
  - HOLD: wait, LCD_EN=0. Length is CLEAR_CYCLES for 0x01, otherwise CMD_CYCLES.
  - LCD_DATA/LCD_RS stay stable from SETUP through the first HOLD cycle.
- States:
  - POWERUP: count POWERUP_CYCLES, then go to INIT.
  - INIT: commands 0x38, 0x0C, 0x01, 0x06 in that order, RS=0. Then go to LINE with DisplayAddr=0.
  - LINE: command 0x80 if DisplayAddr=0, 0xC0 if DisplayAddr=16. Then go to FETCH.
  - FETCH: DisplayAddr held; wait exactly 2 clocks; latch Phrase on the 2nd clock. Then go to WRITE.
  - WRITE: transaction with RS=1 and LCD_DATA=latched Phrase. Then go to NEXT.
  - NEXT: 1 clock. Next state depends on the old DisplayAddr:
    - 15: DisplayAddr becomes 16, go to LINE.
    - 31: DisplayAddr wraps to 0, FrameDone=1 for this clock, go to LINE. Init is not repeated.
    - otherwise: DisplayAddr+1, go to FETCH.
- Phrase changing during WRITE is ignored; the latched value is used. The new value is picked up on the next frame.
- Phrase is not checked; any 8-bit value is written as-is.
- LCD_ON: 1 from the first clock after reset is released.
- LCD_RW: always 0.
- Counters: wide enough for the largest parameter; wait lengths are exact (off-by-one is a bug).
- Character write latency: 2 (FETCH) + 1 + EN_CYCLES + CMD_CYCLES + 1 (NEXT) clocks.

Test Plan:
Bench parameters for all scenarios: POWERUP_CYCLES=20, EN_CYCLES=2, CMD_CYCLES=5, CLEAR_CYCLES=10. A bus monitor captures (RS, DATA) on each LCD_EN rising edge.
1. Release reset -> LCD_EN stays 0 for exactly 20 clocks. Then (0,0x38), (0,0x0C), (0,0x01), (0,0x06), (0,0x80). Gap from EN fall after 0x01 to the next SETUP is 10 clocks; all other gaps are 5.
2. Phrase model = ROM of "ADDR..." patterns with 1-clock registered latency -> 32 RS=1 writes match model[0..31] in order. (0,0xC0) appears between writes 15 and 16. LCD_EN high width is always exactly 2 clocks.
3. End of frame 1 -> FrameDone high exactly one clock. DisplayAddr wraps 31->0. The next EN is (0,0x80) with no re-init.
4. Model data at address 5 changed from '3' to '7' while the WRITE of address 5 is in progress -> frame 1 shows '3', frame 2 shows '7'.
5. Assert resetn=0 for 1 clock while LCD_EN=1 -> LCD_EN=0 and DisplayAddr=0 on the next edge; the full POWERUP+INIT sequence repeats.
6. Whole run -> LCD_RW never 1. LCD_DATA/LCD_RS never change while LCD_EN=1.
